// File: rtl/ram_stream_reader_if.sv
// Block-RAM port bundle shared by RAM slaves and the stream reader master.
// The master drives the request side; rdata returns one cycle after en.
interface ram_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic clk
);
  logic                  en;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master     (input clk, output en, output we, output addr, output wdata, input rdata);
  modport slave      (input clk, input en, input we, input addr, input wdata, output rdata);
  modport read_slave (input clk, input en, input addr, output rdata);
endinterface

// File: rtl/ram_stream_reader.sv
// Fetches a run of RAM words and replays them as a valid/ready stream with a last marker.
// Optional per-transfer address stride is enabled by defining RAM_STREAM_READER_STRIDE_EN.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
`ifdef RAM_STREAM_READER_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] stride,
`endif
  output logic                  busy,
  output logic                  done,
  ram_if.master                 ram,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic                  en_q, en_d;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic [ADDR_WIDTH:0]   popped_q, popped_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop, issue_ok;
  logic [CW+1:0]         committed;
  logic [ADDR_WIDTH-1:0] step, start_step;

`ifdef RAM_STREAM_READER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  assign step       = stride_q;
  assign start_step = stride;
`else
  assign step       = ADDR_WIDTH'(1);
  assign start_step = ADDR_WIDTH'(1);
`endif

  assign ram.en    = en_q;
  assign ram.we    = 1'b0;
  assign ram.addr  = addr_q;
  assign ram.wdata = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      inflight_q <= 1'b0;
      addr_q     <= '0;
      cur_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef RAM_STREAM_READER_STRIDE_EN
      stride_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      inflight_q <= en_q;
      addr_q     <= addr_d;
      cur_q      <= cur_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
`ifdef RAM_STREAM_READER_STRIDE_EN
      stride_q   <= stride_d;
`endif
    end
  end

  // The rdata of a read issued last cycle lands in the FIFO at the end of this cycle.
  always_comb begin
    push    = inflight_q;
    pop     = (count_q != '0) && m_ready;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_q] = ram.rdata;
      wr_d = (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + PW'(1);
    end
  end

  // Credit counts entries held after this cycle's pop plus both reads already on their way.
  always_comb begin
    committed = (CW+2)'(count_q) + (CW+2)'(inflight_q) + (CW+2)'(en_q) - (CW+2)'(pop);
    issue_ok  = (issued_q < len_q) && (committed < (CW+2)'(FIFO_DEPTH));
    state_d   = state_q;
    en_d      = 1'b0;
    addr_d    = addr_q;
    cur_d     = cur_q;
    len_d     = len_q;
    issued_d  = issued_q;
    popped_d  = popped_q + (ADDR_WIDTH+1)'(pop);
`ifdef RAM_STREAM_READER_STRIDE_EN
    stride_d  = stride_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = len;
          issued_d = '0;
          popped_d = '0;
`ifdef RAM_STREAM_READER_STRIDE_EN
          stride_d = stride;
`endif
          if (len != '0) begin
            state_d  = READ;
            en_d     = 1'b1;
            addr_d   = base_addr;
            cur_d    = base_addr + start_step;
            issued_d = (ADDR_WIDTH+1)'(1);
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        if (issue_ok) begin
          en_d     = 1'b1;
          addr_d   = cur_q;
          cur_d    = cur_q + step;
          issued_d = issued_q + (ADDR_WIDTH+1)'(1);
        end
        if (issued_q == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if ((count_d == '0) && !inflight_q && !en_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    m_valid = (count_q != '0);
    m_data  = mem_q[rd_q];
    m_last  = m_valid && (popped_q == len_q - (ADDR_WIDTH+1)'(1));
  end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: a behavioural 1-cycle RAM holding addr*0x11
// plus a negedge monitor that logs addresses, beats and flow-control violations.
module tb_ram_stream_reader;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic [AW-1:0] stride;
  logic          busy, done, m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int startCyc = 0;

  logic [AW-1:0] addrQ[$];
  logic [DW-1:0] beatQ[$];
  logic          lastQ[$];
  int            beatCycQ[$];
  int            doneCycQ[$];
  int            busyCnt = 0;
  int            creditErr = 0;
  int            stallErr = 0;
  int            occ = 0;
  int            infl = 0;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData = '0;

  ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ramBus (.clk(clk));

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
`ifdef RAM_STREAM_READER_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .ram       (ramBus),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] ramWord(input logic [AW-1:0] a);
    return DW'(a) * 32'h11;
  endfunction

  // Behavioural RAM: read data appears the cycle after the request.
  always @(posedge clk) begin
    if (ramBus.en && !ramBus.we) ramBus.rdata <= ramWord(ramBus.addr);
  end

  // Occupancy is rebuilt from observed reads and handshakes to police the credit rule.
  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0;
      infl = 0;
      prevStall = 1'b0;
    end else begin
      if (ramBus.en) addrQ.push_back(ramBus.addr);
      if (ramBus.en && (occ + infl >= DEPTH)) creditErr++;
      if (occ > DEPTH) creditErr++;
      if (prevStall && (!m_valid || m_data !== prevData)) stallErr++;
      if (m_valid && m_ready) begin
        beatQ.push_back(m_data);
        lastQ.push_back(m_last);
        beatCycQ.push_back(cyc);
      end
      if (done) doneCycQ.push_back(cyc);
      if (busy) busyCnt++;
      occ = occ + infl - ((m_valid && m_ready) ? 1 : 0);
      infl = ramBus.en ? 1 : 0;
      prevStall = m_valid && !m_ready;
      prevData = m_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearLogs();
    addrQ.delete();
    beatQ.delete();
    lastQ.delete();
    beatCycQ.delete();
    doneCycQ.delete();
    busyCnt = 0;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW:0] l, input logic [AW-1:0] s);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    len = l;
    stride = s;
    startCyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles, input int readyPeriod);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < maxCycles) begin
      @(posedge clk); #1;
      m_ready = (readyPeriod <= 1) ? 1'b1 : ((n % readyPeriod) == 0);
      n++;
      if (doneCycQ.size() > 0) seen = 1'b1;
    end
    checkOutput("done_seen", 64'(seen), 64'd1);
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic checkBeats(input string tag, input logic [AW-1:0] b, input int n, input int s);
    logic [AW-1:0] a;
    checkOutput({tag, "_beat_count"}, 64'(beatQ.size()), 64'(n));
    checkOutput({tag, "_en_count"}, 64'(addrQ.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i * s);
      checkOutput({tag, "_addr"}, (i < addrQ.size()) ? 64'(addrQ[i]) : 64'hBAD, 64'(a));
      checkOutput({tag, "_data"}, (i < beatQ.size()) ? 64'(beatQ[i]) : 64'hBAD, 64'(ramWord(a)));
      checkOutput({tag, "_last"}, (i < lastQ.size()) ? 64'(lastQ[i]) : 64'hBAD, 64'(i == n - 1));
    end
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    stride = AW'(1);
    m_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_last", 64'(m_last), 64'd0);
    checkOutput("rst_data", 64'(m_data), 64'd0);
    checkOutput("rst_en", 64'(ramBus.en), 64'd0);
    checkOutput("rst_we", 64'(ramBus.we), 64'd0);
    checkOutput("rst_addr", 64'(ramBus.addr), 64'd0);
    checkOutput("rst_wdata", 64'(ramBus.wdata), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] basic run base=0x010 len=4");
    clearLogs();
    applyStimulus(AW'(10'h010), (AW+1)'(4), AW'(1));
    waitDone(40, 1);
    checkBeats("basic", AW'(10'h010), 4, 1);
    for (int i = 0; i < 4; i++)
      checkOutput("basic_beat_cycle", (i < beatCycQ.size()) ? 64'(beatCycQ[i]) : 64'hBAD, 64'(startCyc + 3 + i));
    checkOutput("basic_done_cycle", (doneCycQ.size() > 0) ? 64'(doneCycQ[0]) : 64'hBAD, 64'(startCyc + 7));
    checkOutput("basic_done_pulses", 64'(doneCycQ.size()), 64'd1);
    checkOutput("basic_busy_cycles", 64'(busyCnt), 64'd7);

    $display("[TB] backpressure run base=0x040 len=8");
    clearLogs();
    m_ready = 1'b0;
    applyStimulus(AW'(10'h040), (AW+1)'(8), AW'(1));
    waitDone(200, 3);
    checkBeats("stall", AW'(10'h040), 8, 1);
    checkOutput("stall_credit", 64'(creditErr), 64'd0);
    checkOutput("stall_hold", 64'(stallErr), 64'd0);

    $display("[TB] address wrap base=0x3FE len=4");
    clearLogs();
    applyStimulus(AW'(10'h3FE), (AW+1)'(4), AW'(1));
    waitDone(40, 1);
    checkBeats("wrap", AW'(10'h3FE), 4, 1);

    $display("[TB] zero length");
    clearLogs();
    applyStimulus(AW'(10'h055), (AW+1)'(0), AW'(1));
    waitDone(20, 1);
    checkOutput("zero_done_cycle", (doneCycQ.size() > 0) ? 64'(doneCycQ[0]) : 64'hBAD, 64'(startCyc + 1));
    checkOutput("zero_busy_cycles", 64'(busyCnt), 64'd1);
    checkOutput("zero_en_count", 64'(addrQ.size()), 64'd0);
    checkOutput("zero_beat_count", 64'(beatQ.size()), 64'd0);

    $display("[TB] reset mid-transfer");
    clearLogs();
    applyStimulus(AW'(10'h010), (AW+1)'(6), AW'(1));
    for (int n = 0; n < 30 && beatQ.size() < 2; n++) begin
      @(posedge clk); #1;
    end
    checkOutput("mid_beats_before_reset", 64'(beatQ.size()), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_busy", 64'(busy), 64'd0);
    checkOutput("mid_done", 64'(done), 64'd0);
    checkOutput("mid_valid", 64'(m_valid), 64'd0);
    checkOutput("mid_last", 64'(m_last), 64'd0);
    checkOutput("mid_data", 64'(m_data), 64'd0);
    checkOutput("mid_en", 64'(ramBus.en), 64'd0);
    checkOutput("mid_addr", 64'(ramBus.addr), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clearLogs();
    applyStimulus(AW'(10'h020), (AW+1)'(2), AW'(1));
    waitDone(40, 1);
    checkBeats("after_reset", AW'(10'h020), 2, 1);

`ifdef RAM_STREAM_READER_STRIDE_EN
    $display("[TB] stride run base=5 stride=3 len=3");
    clearLogs();
    applyStimulus(AW'(5), (AW+1)'(3), AW'(3));
    start = 1'b1;
    base_addr = AW'(10'h100);
    len = (AW+1)'(2);
    stride = AW'(1);
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(40, 1);
    checkBeats("stride", AW'(5), 3, 3);
    checkOutput("stride_done_pulses", 64'(doneCycQ.size()), 64'd1);
`endif

    checkOutput("final_credit", 64'(creditErr), 64'd0);
    checkOutput("final_hold", 64'(stallErr), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
